alu_arbiter: RTL

- Shares the single combinational `alu` instance between two requesters: m0 (main datapath) and m1 (multi-cycle/debug sequencer).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are registered into the ALU, and the result plus flags are captured into a response register.
- Sits between the requesters and the `alu` instance; owns the ALU's a/b/aluc inputs.

---
 rtl/alu_arb_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 76 +++++++
 rtl/alu_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice: FSM states, ALUC opcodes,
// response flag bit positions and a small grant-index helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU operation codes (the ALU's contract; the arbiter only forwards them)
  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1110;

  localparam int unsigned FLAG_ZERO  = 3;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_OVF   = 0;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a last_grant register updated on acceptance.
// Optional grant locking is built only when ALU_ARB_LOCK_EN is defined.
module rr_arb2
  import alu_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_lock,
  input  logic       update,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_q;
  logic rr_idx;

  // With both valid the previous winner yields; otherwise the only valid one wins.
  always_comb begin
    rr_idx = (&req_valid) ? ~last_q : req_valid[1];
  end

`ifdef ALU_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  logic          locked_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nx;

  // While locked the owner is last_q, since only it can have been granted since.
  always_comb begin
    gnt_valid = |req_valid;
    gnt_idx   = rr_idx;
    if (locked_q) begin
      gnt_valid = req_valid[last_q];
      gnt_idx   = last_q;
    end
    cnt_nx = locked_q ? cnt_q + 1'b1 : CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else if (update) begin
      if (req_lock[gnt_idx] && (cnt_nx < CW'(LOCK_MAX))) begin
        locked_q <= 1'b1;
        cnt_q    <= cnt_nx;
      end else begin
        locked_q <= 1'b0;
        cnt_q    <= '0;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (^req_lock) ^ LOCK_MAX[0];

  always_comb begin
    gnt_valid = |req_valid;
    gnt_idx   = rr_idx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters (IDLE->EXEC->RESP).
// Optional per-requester grant locking is enabled with ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [7:0]          req_aluc,
  input  logic [1:0]          req_lock,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_r,
  output logic [3:0]          rsp_flags,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_aluc,
  input  logic [DATA_W-1:0]   alu_r,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                alu_negative,
  input  logic                alu_overflow
);

  state_t state_q, state_d;
  logic   gnt_q;
  logic   arb_valid;
  logic   arb_idx;
  logic   accept;

  rr_arb2 #(
    .LOCK_MAX(LOCK_MAX)
  ) u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_lock (req_lock),
    .update   (accept),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          req_ready = onehot2(arb_idx);
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q <= arb_idx;
      end
    end
  end

  // Operands are captured only on acceptance and held until the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_aluc <= '0;
    end else if (accept) begin
      alu_a    <= arb_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
      alu_b    <= arb_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
      alu_aluc <= arb_idx ? req_aluc[7:4] : req_aluc[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_r     <= '0;
      rsp_flags <= '0;
    end else begin
      if (state_q == EXEC) begin
        rsp_r                <= alu_r;
        rsp_flags[FLAG_ZERO]  <= alu_zero;
        rsp_flags[FLAG_CARRY] <= alu_carry;
        rsp_flags[FLAG_NEG]   <= alu_negative;
        rsp_flags[FLAG_OVF]   <= alu_overflow;
        rsp_valid            <= onehot2(gnt_q);
      end else if ((state_q == RESP) && rsp_ready[gnt_q]) begin
        rsp_valid <= '0;
      end
    end
  end

endmodule
